// File: rtl/fwd_unit_pipe_pkg.sv
// Shared constants and types for the operand-forwarding unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fwd_unit_pipe_pkg;

    // Register address width of the integer register file.
    localparam int REG_ADDR_WIDTH = 5;

    // Debug tag that records where each operand came from.
    localparam logic [1:0] FWD_SRC_RF  = 2'd0;
    localparam logic [1:0] FWD_SRC_EX  = 2'd1;
    localparam logic [1:0] FWD_SRC_MEM = 2'd2;
    localparam logic [1:0] FWD_SRC_WB  = 2'd3;

    // Load-use interlock states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } fwd_state_e;

endpackage

// File: rtl/fwd_unit_pipe_fwd_sel_port.sv
// Per-read-port operand selector: youngest producer wins, x0 is always zero.
// Latency: purely combinational.
// Backpressure: none; mem_wen arrives already gated by the caller's suppression.
// Ports: addr/rf_rdata for the port, EX/MEM/WB write-back info, sel_data/sel_src result.
module fwd_sel_port
    import fwd_unit_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = REG_ADDR_WIDTH
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] rf_rdata,
    input  logic            ex_wen,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_waddr,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_wen,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic [XLEN-1:0] sel_data,
    output logic [1:0]      sel_src
);

    always_comb begin
        sel_data = rf_rdata;
        sel_src  = FWD_SRC_RF;
        if (addr == '0) begin
            sel_data = '0;
            sel_src  = FWD_SRC_RF;
        end else if (ex_wen && !ex_is_load && (ex_waddr == addr)) begin
            // A load in EX has no data yet; the interlock covers that case.
            sel_data = ex_result;
            sel_src  = FWD_SRC_EX;
        end else if (mem_wen && (mem_waddr == addr)) begin
            sel_data = mem_result;
            sel_src  = FWD_SRC_MEM;
        end else if (wb_wen && (wb_waddr == addr)) begin
            sel_data = wb_wdata;
            sel_src  = FWD_SRC_WB;
        end
    end

endmodule

// File: rtl/fwd_unit_pipe.sv
// Operand forwarding plus load-use interlock between ID register read and EX.
// Latency: one cycle ID->EX for operands; stall_o is combinational.
// Backpressure: stall_o holds PC/IF/ID and injects bubbles (op_valid=0) into EX.
// Ports: clk/rst, flush, ID read info, EX/MEM/WB producers, stall_o, op_rdata/op_valid/fwd_src.
module fwd_unit_pipe
    import fwd_unit_pipe_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int AW       = REG_ADDR_WIDTH,
    parameter int NUM_RD   = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [NUM_RD*AW-1:0]   id_rs_addr,
    input  logic [NUM_RD-1:0]      id_rs_used,
    input  logic [NUM_RD*XLEN-1:0] rf_rdata,
    input  logic                   ex_wen,
    input  logic                   ex_is_load,
    input  logic [AW-1:0]          ex_waddr,
    input  logic [XLEN-1:0]        ex_result,
    input  logic                   mem_wen,
    input  logic [AW-1:0]          mem_waddr,
    input  logic [XLEN-1:0]        mem_result,
    input  logic                   wb_wen,
    input  logic [AW-1:0]          wb_waddr,
    input  logic [XLEN-1:0]        wb_wdata,
    output logic                   stall_o,
    output logic [NUM_RD*XLEN-1:0] op_rdata,
    output logic                   op_valid,
    output logic [NUM_RD*2-1:0]    fwd_src
);

    // Extra STALL-state cycles beyond the one the live hazard already gives.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

    fwd_state_e state;
    logic [2:0]  cnt;
    logic [AW-1:0] ld_addr_q;

    logic [NUM_RD*XLEN-1:0] sel_data;
    logic [NUM_RD*2-1:0]    sel_src;
    logic [NUM_RD-1:0]      rs_match;
    logic                   hz;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [AW-1:0] addr;
        logic          mem_sup;

        assign addr = id_rs_addr[i*AW +: AW];
        // While stalled the load sits in MEM without final data, so a port
        // reading the stalled destination must not pick up the MEM value.
        assign mem_sup = (state == ST_STALL) && (addr == ld_addr_q);
        assign rs_match[i] = id_rs_used[i] && (addr == ex_waddr);

        fwd_sel_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_sel (
            .addr       (addr),
            .rf_rdata   (rf_rdata[i*XLEN +: XLEN]),
            .ex_wen     (ex_wen),
            .ex_is_load (ex_is_load),
            .ex_waddr   (ex_waddr),
            .ex_result  (ex_result),
            .mem_wen    (mem_wen && !mem_sup),
            .mem_waddr  (mem_waddr),
            .mem_result (mem_result),
            .wb_wen     (wb_wen),
            .wb_waddr   (wb_waddr),
            .wb_wdata   (wb_wdata),
            .sel_data   (sel_data[i*XLEN +: XLEN]),
            .sel_src    (sel_src[i*2 +: 2])
        );
    end

    assign hz = id_valid && ex_wen && ex_is_load && (ex_waddr != '0) && (|rs_match);

    always_comb begin
        stall_o = 1'b0;
        if (rst) begin
            stall_o = 1'b0;
        end else if (state == ST_STALL) begin
            stall_o = 1'b1;
        end else begin
            stall_o = hz && !flush;
        end
    end

    // Interlock FSM. The first stall cycle comes from hz in IDLE; STALL then
    // covers the remaining LOAD_LAT-1 cycles, leaving when the count runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ld_addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hz && !flush && (LOAD_LAT > 1)) begin
                        state     <= ST_STALL;
                        cnt       <= CNT_INIT;
                        ld_addr_q <= ex_waddr;
                    end
                end
                ST_STALL: begin
                    if (flush || (cnt <= 3'd1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ID/EX operand register; flush and stall both inject a bubble and hold data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_rdata <= '0;
            op_valid <= 1'b0;
            fwd_src  <= '0;
        end else if (flush || stall_o) begin
            op_valid <= 1'b0;
        end else begin
            op_valid <= id_valid;
            op_rdata <= sel_data;
            fwd_src  <= sel_src;
        end
    end

endmodule

// File: tb/tb_fwd_unit_pipe.sv
// Self-checking bench for fwd_unit_pipe (XLEN=64, NUM_RD=2, LOAD_LAT=2).
// Latency: expected operands are queued at drive time and checked one edge later.
// Backpressure: stall_o is checked mid-cycle against the expected interlock.
module tb_fwd_unit_pipe;

    typedef struct packed {
        logic         v;
        logic [127:0] d;
        logic [3:0]   s;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         id_valid;
    logic [9:0]   id_rs_addr;
    logic [1:0]   id_rs_used;
    logic [127:0] rf_rdata;
    logic         ex_wen;
    logic         ex_is_load;
    logic [4:0]   ex_waddr;
    logic [63:0]  ex_result;
    logic         mem_wen;
    logic [4:0]   mem_waddr;
    logic [63:0]  mem_result;
    logic         wb_wen;
    logic [4:0]   wb_waddr;
    logic [63:0]  wb_wdata;
    logic         stall_o;
    logic [127:0] op_rdata;
    logic         op_valid;
    logic [3:0]   fwd_src;

    exp_t sb[$];
    exp_t e;
    exp_t got;
    logic [127:0] last_d;
    logic [3:0]   last_s;
    int checks;
    int errors;

    fwd_unit_pipe #(
        .XLEN     (64),
        .AW       (5),
        .NUM_RD   (2),
        .LOAD_LAT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs_addr (id_rs_addr),
        .id_rs_used (id_rs_used),
        .rf_rdata   (rf_rdata),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_waddr   (ex_waddr),
        .ex_result  (ex_result),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_result (mem_result),
        .wb_wen     (wb_wen),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .stall_o    (stall_o),
        .op_rdata   (op_rdata),
        .op_valid   (op_valid),
        .fwd_src    (fwd_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        flush      = 1'b0;
        id_valid   = 1'b0;
        id_rs_addr = '0;
        id_rs_used = '0;
        rf_rdata   = '0;
        ex_wen     = 1'b0;
        ex_is_load = 1'b0;
        ex_waddr   = '0;
        ex_result  = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_result = '0;
        wb_wen     = 1'b0;
        wb_waddr   = '0;
        wb_wdata   = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", got);
        end
        // A live load-use pattern must not raise stall while reset is held.
        id_valid = 1'b1; id_rs_addr = {5'd3, 5'd0}; id_rs_used = 2'b10;
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd3;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: stall_o=%b required 0", stall_o);
        end
        set_idle();
        rst = 1'b0;
        last_d = '0;
        last_s = '0;
    endtask

    task automatic test_ex_fwd();
        set_idle();
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd5}; id_rs_used = 2'b01;
        rf_rdata = {64'h0, 64'h11};
        ex_wen = 1'b1; ex_waddr = 5'd5; ex_result = 64'hAA;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL ex_fwd_stall: stall_o=%b required 0", stall_o);
        end
        sb.push_back('{v: 1'b1, d: {64'h0, 64'hAA}, s: {2'd0, 2'd1}});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ex_fwd: got %h required %h", got, e);
        end
        last_d = e.d; last_s = e.s;
    endtask

    task automatic test_priority();
        logic [63:0] ev0 [4] = '{64'h1, 64'h2, 64'h3, 64'h99};
        logic [63:0] ev1 [4] = '{64'h1, 64'h2, 64'h3, 64'h98};
        logic [1:0]  tag [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            set_idle();
            // Both ports read x7, so selection must be identical on each.
            id_valid = 1'b1; id_rs_addr = {5'd7, 5'd7}; id_rs_used = 2'b11;
            rf_rdata = {64'h98, 64'h99};
            ex_wen  = (i == 0); ex_waddr  = 5'd7; ex_result  = 64'h1;
            mem_wen = (i <= 1); mem_waddr = 5'd7; mem_result = 64'h2;
            wb_wen  = (i <= 2); wb_waddr  = 5'd7; wb_wdata   = 64'h3;
            sb.push_back('{v: 1'b1, d: {ev1[i], ev0[i]}, s: {tag[i], tag[i]}});
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {op_valid, op_rdata, fwd_src};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL priority_%0d: got %h required %h", i, got, e);
            end
            last_d = e.d; last_s = e.s;
        end
    endtask

    task automatic test_x0();
        set_idle();
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd0}; id_rs_used = 2'b11;
        rf_rdata = {64'hFF, 64'hFF};
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd0; ex_result = 64'hFF;
        mem_wen = 1'b1; mem_waddr = 5'd0; mem_result = 64'hFF;
        wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 64'hFF;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: stall_o=%b required 0", stall_o);
        end
        sb.push_back('{v: 1'b1, d: 128'h0, s: 4'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL x0: got %h required %h", got, e);
        end
        last_d = e.d; last_s = e.s;
    endtask

    task automatic test_load_use();
        set_idle();
        id_valid = 1'b1; id_rs_addr = {5'd3, 5'd2}; rf_rdata = {64'h33, 64'h22};
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd3; ex_result = 64'hBAD;
        // Matching port flagged unused: no interlock, and a load is never EX-forwarded.
        id_rs_used = 2'b01;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL unused_port_stall: stall_o=%b required 0", stall_o);
        end
        sb.push_back('{v: 1'b1, d: {64'h33, 64'h22}, s: 4'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL unused_port: got %h required %h", got, e);
        end
        last_d = e.d; last_s = e.s;

        // Stall cycle 1: load in EX.
        id_rs_used = 2'b11;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall1: stall_o=%b required 1", stall_o);
        end
        sb.push_back('{v: 1'b0, d: last_d, s: last_s});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL load_use_bubble1: got %h required %h", got, e);
        end

        // Stall cycle 2: load in MEM, data not final yet.
        ex_wen = 1'b0; ex_is_load = 1'b0;
        mem_wen = 1'b1; mem_waddr = 5'd3; mem_result = 64'hDEAD;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall2: stall_o=%b required 1", stall_o);
        end
        sb.push_back('{v: 1'b0, d: last_d, s: last_s});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL load_use_bubble2: got %h required %h", got, e);
        end

        // Stall released: final load data forwarded from MEM.
        mem_result = 64'h1234;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release: stall_o=%b required 0", stall_o);
        end
        sb.push_back('{v: 1'b1, d: {64'h1234, 64'h22}, s: {2'd2, 2'd0}});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL load_use_fwd: got %h required %h", got, e);
        end
        last_d = e.d; last_s = e.s;
    endtask

    task automatic test_flush();
        set_idle();
        id_valid = 1'b1; id_rs_addr = {5'd3, 5'd1}; id_rs_used = 2'b10;
        rf_rdata = {64'h77, 64'h66};
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd3;
        flush = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_hz_stall: stall_o=%b required 0", stall_o);
        end
        sb.push_back('{v: 1'b0, d: last_d, s: last_s});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL flush_hz: got %h required %h", got, e);
        end
        // FSM must still be IDLE: with no hazard, STALL would force stall_o high.
        set_idle();
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: stall_o=%b required 0", stall_o);
        end
        sb.push_back('{v: 1'b0, d: 128'h0, s: 4'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL flush_after: got %h required %h", got, e);
        end
        last_d = e.d; last_s = e.s;
    endtask

    task automatic test_reset_mid();
        set_idle();
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd4}; id_rs_used = 2'b01;
        rf_rdata = {64'h0, 64'h44};
        sb.push_back('{v: 1'b1, d: {64'h0, 64'h44}, s: 4'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_pre: got %h required %h", got, e);
        end
        // Load-use on x4 to enter STALL.
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd4;
        sb.push_back('{v: 1'b0, d: {64'h0, 64'h44}, s: 4'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_bubble: got %h required %h", got, e);
        end
        ex_wen = 1'b0; ex_is_load = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_in_stall: stall_o=%b required 1", stall_o);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        got = {op_valid, op_rdata, fwd_src};
        checks++;
        if ((got !== '0) || (stall_o !== 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_async: got %h stall_o=%b required 0 and 0", got, stall_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: stall_o=%b required 0", stall_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_d = '0;
        last_s = '0;
        set_idle();
        rst = 1'b1;
        test_reset();
        test_ex_fwd();
        test_priority();
        test_x0();
        test_load_use();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
